// File: rtl/sift_phase_sequencer_pkg.sv
// Shared types for the SIFT phase sequencer: FSM states, status codes, status word layout
// and the next-enabled-stage priority search.
package sift_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_GAP    = 2'd2,
    S_REPORT = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ABORT   = 2'd2
  } status_e;

  localparam int OD_CODE_LSB  = 14;
  localparam int OD_STAGE_LSB = 11;
  localparam int OD_COUNT_LSB = 0;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } stage_pick_t;

  // Lowest set bit of an 8-stage mask; idx stays 0 when nothing is set.
  function automatic stage_pick_t pick_lowest(input logic [7:0] m);
    stage_pick_t p;
    p = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        p.found = 1'b1;
        p.idx   = 3'(i);
      end
    end
    return p;
  endfunction

  // Lowest enabled stage strictly above k.
  function automatic stage_pick_t pick_above(input logic [7:0] m, input logic [2:0] k);
    logic [8:0] below;
    below = (9'd2 << k) - 9'd1;
    return pick_lowest(m & ~below[7:0]);
  endfunction

endpackage

// File: rtl/sift_phase_sequencer_if.sv
// Host/engine-facing bus of the phase sequencer; slave is the sequencer side.
interface sift_phase_sequencer_if
  import sift_seq_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int N_BANKS  = 4,
  parameter int ADDR_W   = 9,
  parameter int TMO_W    = 20
);
  logic                                in_valid;
  logic [N_STAGES-1:0]                 stage_en;
  logic [TMO_W-1:0]                    timeout_lim;
  logic                                abort;
  logic [N_STAGES-1:0]                 stage_start;
  logic [N_STAGES-1:0]                 stage_done;
  logic [N_STAGES*N_BANKS*ADDR_W-1:0]  stage_bank_addr;
  logic [N_STAGES*ADDR_W-1:0]          stage_img_addr;
  logic [N_STAGES-1:0]                 stage_buffer_we;
  logic [N_STAGES-1:0]                 stage_fill_zero;
  logic [N_BANKS*ADDR_W-1:0]           bank_addr;
  logic [ADDR_W-1:0]                   img_addr;
  logic                                buffer_we;
  logic                                fill_zero;
  logic [2:0]                          cur_stage;
  logic                                busy;
  logic                                out_valid;
  logic [15:0]                         out_data;

  modport slave (
    input  in_valid, stage_en, timeout_lim, abort, stage_done,
           stage_bank_addr, stage_img_addr, stage_buffer_we, stage_fill_zero,
    output stage_start, bank_addr, img_addr, buffer_we, fill_zero,
           cur_stage, busy, out_valid, out_data
  );

  modport master (
    output in_valid, stage_en, timeout_lim, abort, stage_done,
           stage_bank_addr, stage_img_addr, stage_buffer_we, stage_fill_zero,
    input  stage_start, bank_addr, img_addr, buffer_we, fill_zero,
           cur_stage, busy, out_valid, out_data
  );
endinterface

// File: rtl/sift_phase_sequencer_stage_mux.sv
// Combinational selector of one stage's memory address and line-buffer control slice;
// drives all zeros when not enabled.
module sift_stage_mux
  import sift_seq_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int N_BANKS  = 4,
  parameter int ADDR_W   = 9
) (
  input  logic                               en,
  input  logic [2:0]                         sel,
  input  logic [N_STAGES*N_BANKS*ADDR_W-1:0] stage_bank_addr,
  input  logic [N_STAGES*ADDR_W-1:0]         stage_img_addr,
  input  logic [N_STAGES-1:0]                stage_buffer_we,
  input  logic [N_STAGES-1:0]                stage_fill_zero,
  output logic [N_BANKS*ADDR_W-1:0]          bank_addr,
  output logic [ADDR_W-1:0]                  img_addr,
  output logic                               buffer_we,
  output logic                               fill_zero
);
  localparam int BW = N_BANKS * ADDR_W;

  // Compare-and-select per stage so an out-of-range sel simply yields zeros.
  always_comb begin
    bank_addr = '0;
    img_addr  = '0;
    buffer_we = 1'b0;
    fill_zero = 1'b0;
    if (en) begin
      for (int k = 0; k < N_STAGES; k++) begin
        if (sel == k[2:0]) begin
          bank_addr = stage_bank_addr[k*BW +: BW];
          img_addr  = stage_img_addr[k*ADDR_W +: ADDR_W];
          buffer_we = stage_buffer_we[k];
          fill_zero = stage_fill_zero[k];
        end
      end
    end
  end
endmodule

// File: rtl/sift_phase_sequencer.sv
// SIFT phase sequencer: runs enabled engines in index order with a one-cycle gap between
// them, muxes the active engine onto the shared memories, and reports a status word.
module sift_phase_sequencer
  import sift_seq_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int N_BANKS  = 4,
  parameter int ADDR_W   = 9,
  parameter int TMO_W    = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sift_phase_sequencer_if.slave  bus
);

  seq_state_e          state_q, state_d;
  logic [2:0]          stg_q, stg_d;
  logic [N_STAGES-1:0] mask_q, mask_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  status_e             code_q, code_d;
  logic [7:0]          ndone_q, ndone_d;

  logic                active;
  logic [N_STAGES-1:0] start_vec;
  logic                done_k;
  logic                tmo_hit;
  stage_pick_t         pick;
  logic [15:0]         od;

  assign active    = (state_q == S_RUN);
  assign start_vec = active ? (N_STAGES'(1) << stg_q) : '0;
  // Only the active stage's done is seen; others are masked by the one-hot start.
  assign done_k    = |(bus.stage_done & start_vec);
  assign tmo_hit   = (bus.timeout_lim != '0) && (cnt_q == bus.timeout_lim - TMO_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stg_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      code_q  <= ST_OK;
      ndone_q <= '0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ndone_q <= ndone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    ndone_d = ndone_q;
    pick    = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mask_d  = bus.stage_en;
          ndone_d = '0;
          code_d  = ST_OK;
          cnt_d   = '0;
          pick    = pick_lowest(8'(bus.stage_en));
          stg_d   = pick.idx;
          state_d = pick.found ? S_RUN : S_REPORT;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + TMO_W'(1);
        // Abort beats done, done beats the watchdog.
        if (bus.abort) begin
          code_d  = ST_ABORT;
          state_d = S_REPORT;
        end else if (done_k) begin
          ndone_d = ndone_q + 8'd1;
          state_d = S_GAP;
        end else if (tmo_hit) begin
          code_d  = ST_TIMEOUT;
          state_d = S_REPORT;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          code_d  = ST_ABORT;
          state_d = S_REPORT;
        end else begin
          pick  = pick_above(8'(mask_q), stg_q);
          cnt_d = '0;
          if (pick.found) begin
            stg_d   = pick.idx;
            state_d = S_RUN;
          end else begin
            state_d = S_REPORT;
          end
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    od = '0;
    if (state_q == S_REPORT) begin
      od[OD_CODE_LSB  +: 2] = code_q;
      od[OD_STAGE_LSB +: 3] = stg_q;
      od[OD_COUNT_LSB +: 8] = ndone_q;
    end
  end

  assign bus.stage_start = start_vec;
  assign bus.cur_stage   = active ? stg_q : 3'd0;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.out_valid   = (state_q == S_REPORT);
  assign bus.out_data    = od;

  sift_stage_mux #(
    .N_STAGES (N_STAGES),
    .N_BANKS  (N_BANKS),
    .ADDR_W   (ADDR_W)
  ) u_mux (
    .en              (active),
    .sel             (stg_q),
    .stage_bank_addr (bus.stage_bank_addr),
    .stage_img_addr  (bus.stage_img_addr),
    .stage_buffer_we (bus.stage_buffer_we),
    .stage_fill_zero (bus.stage_fill_zero),
    .bank_addr       (bus.bank_addr),
    .img_addr        (bus.img_addr),
    .buffer_we       (bus.buffer_we),
    .fill_zero       (bus.fill_zero)
  );

endmodule
